// File: rtl/imem_prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: widths, state encoding
// and IM write-enable patterns.
package imem_prog_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned WEN_W  = 4;

    localparam logic [WEN_W-1:0] IM_WEN_WORD = 4'b1111;
    localparam logic [WEN_W-1:0] IM_WEN_IDLE = 4'b0000;

    typedef enum logic [2:0] {
        ST_HDR0    = 3'd0,
        ST_HDR1    = 3'd1,
        ST_CHK_LEN = 3'd2,
        ST_DATA    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_CSUM    = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_bytes(input state_t s);
        return s inside {ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM};
    endfunction

endpackage

// File: rtl/imem_prog_loader_byte_word_packer.sv
// Collects stream bytes little-endian into 32-bit words; flags the byte that completes a word.
module imem_prog_loader_byte_word_packer
    import imem_prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_ready_c
);

    logic [IDX_W-1:0]         idx;
    logic [WORD_W-BYTE_W-1:0] partial;

    // Newest byte enters at the top so the first byte of a word ends up in [7:0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            partial <= '0;
        end else if (clear) begin
            idx     <= '0;
            partial <= '0;
        end else if (push) begin
            idx     <= idx + IDX_W'(1);
            partial <= {byte_in, partial[WORD_W-BYTE_W-1:BYTE_W]};
        end
    end

    assign word_c       = {byte_in, partial};
    assign word_ready_c = push && (idx == IDX_W'(3));

endmodule

// File: rtl/imem_prog_loader.sv
// Streams a length-prefixed, XOR-checksummed program into the instruction memory and
// holds the core in reset until a complete, valid frame has been written.
module imem_prog_loader
    import imem_prog_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter logic [CNT_W-1:0]  MAX_WORDS = 16'd16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic [WEN_W-1:0]  im_w_en,
    output logic [ADDR_W-1:0] im_address,
    output logic [WORD_W-1:0] im_write_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded
);

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    len;
    logic [BYTE_W-1:0]   acc;
    logic                accept_c;
    logic                restart_ok_c;
    logic                data_push_c;
    logic [WORD_W-1:0]   word_c;
    logic                word_ready_c;

    assign accept_c     = in_valid && in_ready;
    assign restart_ok_c = restart && ((state == ST_DONE) || (state == ST_ERROR));
    assign data_push_c  = accept_c && (state == ST_DATA);

    imem_prog_loader_byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (restart_ok_c),
        .push         (data_push_c),
        .byte_in      (in_data),
        .word_c       (word_c),
        .word_ready_c (word_ready_c)
    );

    // Next-state decode.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_HDR0:    if (accept_c) next_state = ST_HDR1;
            ST_HDR1:    if (accept_c) next_state = ST_CHK_LEN;
            ST_CHK_LEN: begin
                if (len > MAX_WORDS)      next_state = ST_ERROR;
                else if (len == '0)       next_state = ST_CSUM;
                else                      next_state = ST_DATA;
            end
            ST_DATA:    if (word_ready_c) next_state = ST_WRITE;
            ST_WRITE:   next_state = ((words_loaded + CNT_W'(1)) == len) ? ST_CSUM : ST_DATA;
            ST_CSUM:    if (accept_c) next_state = (in_data == acc) ? ST_DONE : ST_ERROR;
            ST_DONE,
            ST_ERROR:   if (restart) next_state = ST_HDR0;
            default:    next_state = ST_HDR0;
        endcase
    end

    // State register, datapath and outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_HDR0;
            in_ready      <= 1'b1;
            im_w_en       <= IM_WEN_IDLE;
            im_address    <= BASE_ADDR;
            im_write_data <= '0;
            cpu_hold      <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            words_loaded  <= '0;
            len           <= '0;
            acc           <= '0;
        end else begin
            state    <= next_state;
            in_ready <= accepts_bytes(next_state);
            im_w_en  <= (next_state == ST_WRITE) ? IM_WEN_WORD : IM_WEN_IDLE;
            cpu_hold <= (next_state != ST_DONE);
            busy     <= !((next_state == ST_DONE) || (next_state == ST_ERROR));
            done     <= (next_state == ST_DONE);
            err      <= (next_state == ST_ERROR);

            if (accept_c && (state == ST_HDR0)) len[BYTE_W-1:0]       <= in_data;
            if (accept_c && (state == ST_HDR1)) len[CNT_W-1:BYTE_W]   <= in_data;
            if (data_push_c)                    acc                   <= acc ^ in_data;
            if (word_ready_c)                   im_write_data         <= word_c;

            if (state == ST_WRITE) begin
                words_loaded <= words_loaded + CNT_W'(1);
                if (next_state == ST_DATA) im_address <= im_address + ADDR_W'(4);
            end

            if (restart_ok_c) begin
                acc          <= '0;
                words_loaded <= '0;
                im_address   <= BASE_ADDR;
            end
        end
    end

endmodule
